// File: rtl/mealy_pkg.sv
// Shared types for the mealy_fsm front end: the 2-bit input symbol and its idle value.
package mealy_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;

  // Counter width able to hold 0..n-1; a disabled (n<=1) counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus a whole-vector debouncer: one candidate, one saturating counter.
// accept pulses in the cycle before stable takes the candidate value.
module sync_debounce
  import mealy_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cand,
  output logic [WIDTH-1:0] stable,
  output logic             accept
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = (cnt_q == CNT_MAX) && (cand_q != stable_q);

    // Any movement of the synchronised vector restarts the settle count.
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (accept) begin
      stable_d = cand_q;
    end
  end

  assign cand   = cand_q;
  assign stable = stable_q;

endmodule

// File: rtl/mealy_input_conditioner.sv
// Button front end for mealy_fsm: debounced symbol strobe on en with x, plus optional auto-repeat.
module mealy_input_conditioner
  import mealy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  output logic [1:0] x,
  output logic       en
);

  localparam int               RPT_W     = cnt_width(REPEAT_CYCLES);
  localparam bit               REPEAT_ON = (REPEAT_CYCLES > 0);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_ON ? REPEAT_CYCLES - 1 : 0);

  sym_t             cand;
  sym_t             stable;
  logic             accept;

  sym_t             x_q, x_d;
  logic             en_q, en_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;

  sync_debounce #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_raw),
    .cand  (cand),
    .stable(stable),
    .accept(accept)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= SYM_IDLE;
      en_q  <= 1'b0;
      rpt_q <= '0;
    end else begin
      x_q   <= x_d;
      en_q  <= en_d;
      rpt_q <= rpt_d;
    end
  end

  always_comb begin
    x_d   = x_q;
    en_d  = 1'b0;
    rpt_d = rpt_q;

    // An accept wins over a repeat tick; releases update stable but never strobe.
    if (accept) begin
      rpt_d = '0;
      if (cand != SYM_IDLE) begin
        x_d  = cand;
        en_d = 1'b1;
      end
    end else if (stable == SYM_IDLE || !REPEAT_ON) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      en_d  = 1'b1;
      rpt_d = '0;
    end else begin
      rpt_d = rpt_q + 1'b1;
    end
  end

  assign x  = x_q;
  assign en = en_q;

endmodule

// File: tb/tb_mealy_input_conditioner.sv
// Directed bench: dut0 without repeat, dut1 with REPEAT_CYCLES=16, both DEBOUNCE_CYCLES=4.
module tb_mealy_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn0, btn1;
  logic [1:0] x0, x1;
  logic       en0, en1;

  int n_checks = 0;
  int n_pass   = 0;

  logic       en0_log [0:63];
  logic       en1_log [0:63];
  logic [1:0] x0_log  [0:63];
  logic [1:0] x1_log  [0:63];
  int         en0_cnt, en1_cnt;

  always #5 clk = ~clk;

  mealy_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .btn_raw(btn0), .x(x0), .en(en0)
  );

  mealy_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst), .btn_raw(btn1), .x(x1), .en(en1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive both button inputs at a falling edge and log outputs for n cycles.
  // Log index k holds the outputs in the cycle after rising edge E_k (E0 = first sampling edge).
  task automatic hold(input logic [1:0] v0, input logic [1:0] v1, input int n);
    btn0    = v0;
    btn1    = v1;
    en0_cnt = 0;
    en1_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en0_log[k] = en0;
      en1_log[k] = en1;
      x0_log[k]  = x0;
      x1_log[k]  = x1;
      if (en0) en0_cnt++;
      if (en1) en1_cnt++;
    end
    $display("hold btn0=%b btn1=%b cycles=%0d strobes0=%0d strobes1=%0d x0=%b x1=%b",
             v0, v1, n, en0_cnt, en1_cnt, x0, x1);
  endtask

  initial begin
    int tot;

    // Reset with buttons already pressed.
    rst  = 1'b1;
    btn0 = 2'b11;
    btn1 = 2'b11;
    @(negedge clk);
    chk("rst_x0_c1", x0, 0);
    chk("rst_en0_c1", en0, 0);
    @(negedge clk);
    chk("rst_x0_c2", x0, 0);
    chk("rst_en0_c2", en0, 0);
    chk("rst_en1_c2", en1, 0);
    rst = 1'b0;
    hold(2'b11, 2'b11, 10);
    chk("rst_first_en0_e6", en0_log[6], 1);
    chk("rst_first_x0_e6", x0_log[6], 3);
    chk("rst_first_en0_e5", en0_log[5], 0);
    chk("rst_first_cnt0", en0_cnt, 1);
    chk("rst_first_en1_e6", en1_log[6], 1);
    chk("rst_first_x1_e6", x1_log[6], 3);

    // Return both to idle and clear x again.
    hold(2'b00, 2'b00, 10);
    chk("release_cnt0", en0_cnt, 0);
    chk("release_x0_holds", x0, 3);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_x0", x0, 0);

    // Bounce: every run at the synchroniser is shorter than the debounce window.
    hold(2'b01, 2'b00, 3); tot = en0_cnt;
    hold(2'b00, 2'b00, 1); tot += en0_cnt;
    hold(2'b01, 2'b00, 2); tot += en0_cnt;
    hold(2'b00, 2'b00, 12); tot += en0_cnt;
    chk("bounce_strobes", tot, 0);
    chk("bounce_x0", x0, 0);

    // Clean press, held: one strobe only.
    hold(2'b01, 2'b00, 20);
    chk("press_en0_e6", en0_log[6], 1);
    chk("press_x0_e6", x0_log[6], 1);
    chk("press_en0_e7", en0_log[7], 0);
    chk("press_cnt0", en0_cnt, 1);

    // Direct change 01 -> 11 is a new symbol.
    hold(2'b11, 2'b00, 12);
    chk("chg_x0_e5", x0_log[5], 1);
    chk("chg_en0_e6", en0_log[6], 1);
    chk("chg_x0_e6", x0_log[6], 3);
    chk("chg_cnt0", en0_cnt, 1);
    hold(2'b00, 2'b00, 12);
    chk("chg_release_cnt0", en0_cnt, 0);
    chk("chg_release_x0", x0, 3);

    // Auto-repeat on dut1.
    hold(2'b00, 2'b10, 45);
    chk("rpt_en1_e6", en1_log[6], 1);
    chk("rpt_en1_e21", en1_log[21], 0);
    chk("rpt_en1_e22", en1_log[22], 1);
    chk("rpt_en1_e38", en1_log[38], 1);
    chk("rpt_x1_e38", x1_log[38], 2);
    chk("rpt_cnt1", en1_cnt, 3);
    chk("rpt_cnt0_idle", en0_cnt, 0);
    hold(2'b00, 2'b00, 20);
    chk("rpt_release_cnt1", en1_cnt, 0);
    hold(2'b00, 2'b10, 30);
    chk("rpt2_en1_e6", en1_log[6], 1);
    chk("rpt2_en1_e22", en1_log[22], 1);
    chk("rpt2_cnt1", en1_cnt, 2);
    hold(2'b00, 2'b00, 12);

    // Reset pulse at E4 while 01 is held discards the candidate.
    hold(2'b01, 2'b00, 4);
    chk("mid_cnt0_pre", en0_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en0", en0, 0);
    chk("mid_rst_x0", x0, 0);
    rst = 1'b0;
    hold(2'b01, 2'b00, 12);
    chk("mid_en0_old_e6", en0_log[1], 0);
    chk("mid_en0_e6", en0_log[6], 1);
    chk("mid_x0_e6", x0_log[6], 1);
    chk("mid_cnt0", en0_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
